// File: rtl/cl_mem_order_ctrl.sv
// Memory-ordering sequencer beside the ID stage.
// Tracks outstanding remote requests and the lr.aq reservation, and raises a
// single stall that holds the ID instruction until its ordering constraint is met.
// Optional stall statistics counter: define CL_MEM_ORDER_STATS_EN to build it.
module cl_mem_order_ctrl #(
  parameter int unsigned max_out_p    = 16,
  parameter int unsigned cnt_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    id_valid_i,
  input  logic                    id_is_mem_op_i,
  input  logic                    id_is_fence_i,
  input  logic                    id_is_swap_aq_i,
  input  logic                    id_is_swap_rl_i,
  input  logic                    id_is_lr_acq_i,
  input  logic                    mem_issue_i,
  input  logic                    mem_resp_i,
  input  logic                    lr_break_i,
  output logic                    stall_o,
  output logic [cnt_width_lp-1:0] out_cnt_o,
  output logic                    reserved_o,
  output logic                    underflow_o,
  output logic [31:0]             stall_cycles_o
);

  typedef enum logic [1:0] {StIdle, StDrain, StAqHold, StLrHold} state_e;

  localparam logic [cnt_width_lp-1:0] MaxCnt = cnt_width_lp'(max_out_p);

  state_e                  state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    reserved_q, reserved_d;
  logic                    underflow_q, underflow_d;
  logic                    aq_seen_q, aq_seen_d;
  logic                    stall;
  logic                    cnt_zero, cnt_full;
  logic                    id_mem, id_order, credit_stall;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_full = (cnt_q == MaxCnt);
  // AMO/LR flags imply a memory access even if the decoder leaves mem_op low.
  assign id_mem   = id_is_mem_op_i | id_is_swap_aq_i | id_is_swap_rl_i | id_is_lr_acq_i;
  assign id_order = id_is_fence_i | id_is_swap_rl_i;
  assign credit_stall = id_valid_i & id_mem & cnt_full;

  // Stall generation and FSM next state; depends only on ID flags and registered state.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    aq_seen_d  = aq_seen_q;
    reserved_d = reserved_q;
    if (lr_break_i) reserved_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (id_valid_i & id_order & ~cnt_zero) begin
          stall   = 1'b1;
          state_d = StDrain;
        end else if (credit_stall) begin
          stall = 1'b1;
        end else if (id_valid_i & id_is_swap_aq_i) begin
          state_d   = StAqHold;
          aq_seen_d = 1'b0;
        end else if (id_valid_i & id_is_lr_acq_i) begin
          state_d    = StLrHold;
          reserved_d = 1'b1;
        end
      end
      StDrain: begin
        stall = 1'b1;
        if (cnt_zero) state_d = StIdle;
      end
      StAqHold: begin
        stall     = (id_valid_i & (id_mem | id_is_fence_i)) | credit_stall;
        // Skip the entry cycle so the swap's own request is visible in the count.
        aq_seen_d = 1'b1;
        if (aq_seen_q & cnt_zero) state_d = StIdle;
      end
      StLrHold: begin
        stall = (id_valid_i & id_mem) | credit_stall;
        if (lr_break_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outstanding-request counter and sticky underflow flag.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    if (mem_issue_i & ~mem_resp_i) begin
      if (!cnt_full) cnt_d = cnt_q + cnt_width_lp'(1);
    end else if (mem_resp_i & ~mem_issue_i) begin
      if (cnt_zero) underflow_d = 1'b1;
      else          cnt_d = cnt_q - cnt_width_lp'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      reserved_q  <= 1'b0;
      underflow_q <= 1'b0;
      aq_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reserved_q  <= reserved_d;
      underflow_q <= underflow_d;
      aq_seen_q   <= aq_seen_d;
    end
  end

  assign stall_o     = stall;
  assign out_cnt_o   = cnt_q;
  assign reserved_o  = reserved_q;
  assign underflow_o = underflow_q;

`ifdef CL_MEM_ORDER_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of cycles where a valid ID instruction is held.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (id_valid_i & stall & ~(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Statistics register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) stall_cycles_q <= '0;
    else         stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles_o = stall_cycles_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cl_mem_order_ctrl.sv
// Directed self-checking bench for cl_mem_order_ctrl.
// Main instance uses the default credit limit; a second instance with
// max_out_p = 4 exercises the credit-limit stall.
module tb_cl_mem_order_ctrl;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset_i;
  logic        id_valid, id_mem, id_fence, id_aq, id_rl, id_lr;
  logic        mem_issue, mem_resp, lr_break;
  logic        stall;
  logic [4:0]  out_cnt;
  logic        reserved, underflow;
  logic [31:0] stall_cycles;

  logic        c_valid, c_mem, c_issue, c_resp;
  logic        c_stall;
  logic [2:0]  c_cnt;
  logic        c_reserved, c_underflow;
  logic [31:0] c_stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  cl_mem_order_ctrl dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .id_valid_i     (id_valid),
    .id_is_mem_op_i (id_mem),
    .id_is_fence_i  (id_fence),
    .id_is_swap_aq_i(id_aq),
    .id_is_swap_rl_i(id_rl),
    .id_is_lr_acq_i (id_lr),
    .mem_issue_i    (mem_issue),
    .mem_resp_i     (mem_resp),
    .lr_break_i     (lr_break),
    .stall_o        (stall),
    .out_cnt_o      (out_cnt),
    .reserved_o     (reserved),
    .underflow_o    (underflow),
    .stall_cycles_o (stall_cycles)
  );

  cl_mem_order_ctrl #(.max_out_p(4)) dut4 (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .id_valid_i     (c_valid),
    .id_is_mem_op_i (c_mem),
    .id_is_fence_i  (1'b0),
    .id_is_swap_aq_i(1'b0),
    .id_is_swap_rl_i(1'b0),
    .id_is_lr_acq_i (1'b0),
    .mem_issue_i    (c_issue),
    .mem_resp_i     (c_resp),
    .lr_break_i     (1'b0),
    .stall_o        (c_stall),
    .out_cnt_o      (c_cnt),
    .reserved_o     (c_reserved),
    .underflow_o    (c_underflow),
    .stall_cycles_o (c_stall_cycles)
  );

  // An issue at the credit limit must never be presented.
  always @(posedge clk_i) begin
    if (mem_issue) begin
      n_cmp++;
      if (out_cnt == 5'd16) begin
        n_fail++;
        $display("FAIL issue_at_limit: count %0d required below 16", out_cnt);
      end
    end
    if (c_issue) begin
      n_cmp++;
      if (c_cnt == 3'd4) begin
        n_fail++;
        $display("FAIL issue_at_limit4: count %0d required below 4", c_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_inputs;
    id_valid = 1'b0; id_mem = 1'b0; id_fence = 1'b0; id_aq = 1'b0; id_rl = 1'b0;
    id_lr = 1'b0; mem_issue = 1'b0; mem_resp = 1'b0; lr_break = 1'b0;
    c_valid = 1'b0; c_mem = 1'b0; c_issue = 1'b0; c_resp = 1'b0;
  endtask

  task automatic do_reset;
    clr_inputs();
    reset_i = 1'b1;
    #3;
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    clr_inputs();
    reset_i = 1'b1;
    #2;
    n_cmp++; if (out_cnt !== 5'd0) begin n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", out_cnt); end
    n_cmp++; if (reserved !== 1'b0) begin n_fail++;
      $display("FAIL reset_reserved: got %b want 0", reserved); end
    n_cmp++; if (underflow !== 1'b0) begin n_fail++;
      $display("FAIL reset_underflow: got %b want 0", underflow); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++;
      $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_fail++;
      $display("FAIL reset_stats: got %0d want 0", stall_cycles); end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_fence_drain;
    logic exp_stall;
    do_reset();
    // Zero-latency fence with nothing outstanding.
    id_valid = 1'b1; id_fence = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++;
      $display("FAIL fence_zero_lat: stall got %b want 0", stall); end
    tick();
    clr_inputs();
    for (int i = 0; i < 3; i++) begin
      mem_issue = 1'b1;
      tick();
    end
    mem_issue = 1'b0;
    n_cmp++; if (out_cnt !== 5'd3) begin n_fail++;
      $display("FAIL fence_cnt3: got %0d want 3", out_cnt); end
    // Fence presented at c=0; responses at c=6,7,8; stall through c=9; fires c=10.
    for (int c = 0; c <= 10; c++) begin
      id_valid = 1'b1; id_fence = 1'b1;
      mem_resp = (c >= 6 && c <= 8);
      #1;
      exp_stall = (c <= 9);
      n_cmp++; if (stall !== exp_stall) begin n_fail++;
        $display("FAIL fence_drain c=%0d: stall got %b want %b", c, stall, exp_stall); end
      if (c == 9) begin
        n_cmp++; if (out_cnt !== 5'd0) begin n_fail++;
          $display("FAIL fence_cnt0: got %0d want 0", out_cnt); end
      end
      tick();
    end
    clr_inputs();
  endtask

  task automatic test_simultaneous;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_issue = 1'b1;
      tick();
    end
    mem_issue = 1'b1; mem_resp = 1'b1;
    tick();
    clr_inputs();
    n_cmp++; if (out_cnt !== 5'd5) begin n_fail++;
      $display("FAIL simul_cnt: got %0d want 5", out_cnt); end
    for (int i = 0; i < 5; i++) begin
      mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    n_cmp++; if (out_cnt !== 5'd0 || underflow !== 1'b0) begin n_fail++;
      $display("FAIL simul_drain: cnt %0d uf %b want 0 0", out_cnt, underflow); end
  endtask

  task automatic test_credit_limit;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      c_issue = 1'b1;
      tick();
    end
    c_issue = 1'b0;
    n_cmp++; if (c_cnt !== 3'd4) begin n_fail++;
      $display("FAIL credit_cnt: got %0d want 4", c_cnt); end
    c_valid = 1'b1; c_mem = 1'b1; c_resp = 1'b1;
    #1;
    n_cmp++; if (c_stall !== 1'b1) begin n_fail++;
      $display("FAIL credit_stall: got %b want 1", c_stall); end
    tick();
    c_resp = 1'b0;
    #1;
    n_cmp++; if (c_stall !== 1'b0 || c_cnt !== 3'd3) begin n_fail++;
      $display("FAIL credit_fire: stall %b cnt %0d want 0 3", c_stall, c_cnt); end
    tick();
    clr_inputs();
  endtask

  task automatic test_swap_aq;
    logic exp_stall;
    do_reset();
    id_valid = 1'b1; id_aq = 1'b1; id_mem = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++;
      $display("FAIL aq_fire: stall got %b want 0", stall); end
    tick();
    // Add while the swap's request issues.
    id_aq = 1'b0; id_mem = 1'b0; mem_issue = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++;
      $display("FAIL aq_add: stall got %b want 0", stall); end
    tick();
    mem_issue = 1'b0;
    // Store at c=2; response at c=3; count 0 at c=4; store fires c=5.
    for (int c = 2; c <= 5; c++) begin
      id_valid = 1'b1; id_mem = 1'b1;
      mem_resp = (c == 3);
      #1;
      exp_stall = (c <= 4);
      n_cmp++; if (stall !== exp_stall) begin n_fail++;
        $display("FAIL aq_store c=%0d: stall got %b want %b", c, stall, exp_stall); end
      tick();
    end
    clr_inputs();
  endtask

  task automatic test_lr_acq;
    logic exp_stall;
    do_reset();
    id_valid = 1'b1; id_lr = 1'b1; id_mem = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++;
      $display("FAIL lr_fire: stall got %b want 0", stall); end
    tick();
    id_lr = 1'b0; id_mem = 1'b0;
    #1;
    n_cmp++; if (reserved !== 1'b1 || stall !== 1'b0) begin n_fail++;
      $display("FAIL lr_hold_add: reserved %b stall %b want 1 0", reserved, stall); end
    tick();
    // Load from c=2; break at c=4; load fires c=5.
    for (int c = 2; c <= 5; c++) begin
      id_valid = 1'b1; id_mem = 1'b1;
      lr_break = (c == 4);
      #1;
      exp_stall = (c <= 4);
      n_cmp++; if (stall !== exp_stall || reserved !== exp_stall) begin n_fail++;
        $display("FAIL lr_load c=%0d: stall %b reserved %b want %b %b",
                 c, stall, reserved, exp_stall, exp_stall); end
      tick();
    end
    clr_inputs();
  endtask

  task automatic test_reset_underflow;
    do_reset();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    n_cmp++; if (underflow !== 1'b1 || out_cnt !== 5'd0) begin n_fail++;
      $display("FAIL uf_pre: uf %b cnt %0d want 1 0", underflow, out_cnt); end
    for (int i = 0; i < 2; i++) begin
      mem_issue = 1'b1;
      tick();
    end
    mem_issue = 1'b0;
    id_valid = 1'b1; id_fence = 1'b1;
    tick();
    n_cmp++; if (stall !== 1'b1 || out_cnt !== 5'd2) begin n_fail++;
      $display("FAIL drain_pre: stall %b cnt %0d want 1 2", stall, out_cnt); end
    #2;
    reset_i = 1'b1;
    id_valid = 1'b0; id_fence = 1'b0;
    #1;
    n_cmp++; if (out_cnt !== 5'd0 || underflow !== 1'b0 || reserved !== 1'b0) begin n_fail++;
      $display("FAIL midreset: cnt %0d uf %b res %b want 0 0 0", out_cnt, underflow, reserved); end
    n_cmp++; if (stall !== 1'b0 || stall_cycles !== 32'd0) begin n_fail++;
      $display("FAIL midreset_stall: stall %b stats %0d want 0 0", stall, stall_cycles); end
    reset_i = 1'b0;
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    n_cmp++; if (underflow !== 1'b1 || out_cnt !== 5'd0) begin n_fail++;
      $display("FAIL uf_post: uf %b cnt %0d want 1 0", underflow, out_cnt); end
  endtask

  initial begin
    clr_inputs();
    reset_i = 1'b0;
    tick();
    test_reset();
    test_fence_drain();
    test_simultaneous();
    test_credit_limit();
    test_swap_aq();
    test_lr_acq();
    test_reset_underflow();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cl_mem_order_ctrl.md
# cl_mem_order_ctrl

Memory-ordering sequencer for the vanilla core. It sits beside the ID stage and consumes the decoder's memory-order flags: fence, amoswap.aq, amoswap.rl, lr.aq and mem-op. It tracks outstanding remote memory requests and the load-reservation state. It produces a single stall that holds an instruction in ID until its ordering constraint is met.

## Interface
Parameters:
- max_out_p, 16: maximum outstanding remote requests (credits); must be ≥ 1.
- cnt_width_lp, `$clog2(max_out_p+1)`: derived counter width.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  decoded instruction present in ID.
- id_is_mem_op_i  in  1  ID instruction is a load, store or AMO.
- id_is_fence_i  in  1  ID instruction is FENCE.
- id_is_swap_aq_i  in  1  ID instruction is amoswap.aq.
- id_is_swap_rl_i  in  1  ID instruction is amoswap.rl.
- id_is_lr_acq_i  in  1  ID instruction is lr.w.aq.
- mem_issue_i  in  1  remote request accepted by network this cycle.
- mem_resp_i  in  1  remote response returned this cycle.
- lr_break_i  in  1  reservation broken by a remote store to the reserved address.
- stall_o  out  1  hold ID this cycle.
- out_cnt_o  out  cnt_width_lp  outstanding-request count.
- reserved_o  out  1  reservation currently held.
- underflow_o  out  1  sticky error: response received with count 0.
- stall_cycles_o  out  32  stall statistics; see Configuration.

## Operation
- id_fire = id_valid_i & ~stall_o. Instruction-driven state changes occur only on id_fire.
- Counter update:
  - +1 on mem_issue_i, −1 on mem_resp_i.
  - Both asserted in the same cycle: count unchanged.
  - mem_resp_i at 0 (without mem_issue_i): count stays 0 and underflow_o sets. underflow_o is cleared only by reset.
  - mem_issue_i at max_out_p is illegal. The block prevents it through stall_o; the bench checks it never happens.
- FSM states: IDLE, DRAIN, AQ_HOLD, LR_HOLD.
- IDLE:
  - An ID fence or swap_rl with out_cnt_o ≠ 0 stalls and goes to DRAIN.
  - With out_cnt_o = 0, it fires immediately.
  - On a swap_aq fire, go to AQ_HOLD.
  - On an lr_acq fire, go to LR_HOLD and set the reservation.
- DRAIN:
  - stall_o = 1.
  - When the registered count is 0, go to IDLE. The pending instruction fires in the following cycle.
- AQ_HOLD:
  - Any ID mem op, fence or AMO stalls. Non-memory instructions fire.
  - Go to IDLE when the count is 0 and the cycle is at least the second one after entry, so the swap's own request has been counted.
- LR_HOLD:
  - ID mem ops stall.
  - Go to IDLE on lr_break_i, which also clears reserved_o.
- Credit limit, in any state: an ID mem op stalls while out_cnt_o = max_out_p.
- Priority when several stall causes coincide: any cause stalls. The FSM transition follows the state rules above, with DRAIN > AQ_HOLD > LR_HOLD.
- lr_break_i while not in LR_HOLD: clears reserved_o only; no state change.
- A plain (non-acquire) LR is not tracked here.

## Timing
- stall_o is combinational from the ID flags and the registered state/count; it is never a function of mem_issue_i or mem_resp_i in the same cycle.
- All state, counter and flag updates take effect at the clk_i rising edge.
- Zero-latency case: a fence with count 0 in IDLE fires in the same cycle it is presented.
- Drain latency: the last response arrives in cycle N, the count reads 0 in N+1, and the FSM returns to IDLE with the fence firing in N+2.
- reset_i asserted asynchronously, at any point including mid-DRAIN or mid-LR_HOLD:
  - state = IDLE, out_cnt_o = 0, reserved_o = 0, underflow_o = 0, stall_cycles_o = 0.
  - stall_o then follows the inputs, which is 0 for idle inputs.

## Configuration
- CL_MEM_ORDER_STATS_EN defined: stall_cycles_o increments on every cycle with id_valid_i & stall_o, saturating at 2^32−1.
- Not defined: stall_cycles_o is tied to 0 and the counter logic is not built.

## Test plan
- Fence drain:
  - Stimulus: issue 3 requests, present a fence, return responses in cycles 10, 11 and 12.
  - Required: stall_o = 1 from fence presentation through cycle 13; the fence fires in cycle 14; out_cnt_o returns to 0.
- Simultaneous issue and response: with count 5, assert mem_issue_i and mem_resp_i together → count stays 5.
- Credit limit: with max_out_p = 4 and count 4, present a load → stall_o = 1; one response → the load fires the next cycle.
- swap_aq ordering:
  - Stimulus: fire swap_aq, then present an add, then a store.
  - Required: the add fires; the store stalls until the swap's response drives the count to 0.
- lr_acq:
  - Stimulus: fire lr_acq (reserved_o = 1), then present a load; assert lr_break_i in cycle 20.
  - Required: the load fires in cycle 21; reserved_o = 0.
- Reset and underflow:
  - Stimulus: assert reset_i mid-DRAIN with count 2.
  - Required: all outputs reset immediately.
  - A subsequent mem_resp_i at count 0 sets underflow_o = 1 and the count stays 0.
